// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the memory-domain PLL lock sequencer.
// State encoding is visible on the debug state port, so values are fixed.
package pll_seq_pkg;

    localparam int RETRY_W    = 4;
    localparam int LOSS_CNT_W = 16;

    typedef enum logic [2:0] {
        ASSERT_RST = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } seq_state_e;

    function automatic logic [RETRY_W-1:0] retry_inc(
        input logic [RETRY_W-1:0] cnt
    );
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and reset-tree-side signals of the lock sequencer.
// loss_cnt exists only when PLL_SEQ_LOSS_CNT_EN is defined.
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic               pll_lock;
    logic               relock_req;
    logic               pll_reset;
    logic               rst_out;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0]         state;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt;

    modport master (
        input  pll_lock,
        input  relock_req,
        output pll_reset,
        output rst_out,
        output ready,
        output fault,
        output retry_cnt,
        output state,
        output loss_cnt
    );

    modport slave (
        output pll_lock,
        output relock_req,
        input  pll_reset,
        input  rst_out,
        input  ready,
        input  fault,
        input  retry_cnt,
        input  state,
        input  loss_cnt
    );
`else
    modport master (
        input  pll_lock,
        input  relock_req,
        output pll_reset,
        output rst_out,
        output ready,
        output fault,
        output retry_cnt,
        output state
    );

    modport slave (
        output pll_lock,
        output relock_req,
        input  pll_reset,
        input  rst_out,
        input  ready,
        input  fault,
        input  retry_cnt,
        input  state
    );
`endif

endinterface

// File: rtl/pll_lock_sequencer_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Output is the last stage; STAGES must be at least 2.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor releasing the memory-domain reset once lock is stable.
// Define PLL_SEQ_LOSS_CNT_EN to add the loss_cnt lock-loss counter output.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRIES      = 4,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pll_lock_sequencer_if.master bus
);

    localparam int PULSE_W  = $clog2(RST_PULSE_CYC + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);

    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYC - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0]  RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);

    logic lock_s;

    seq_state_e          state_q, state_d;
    logic [PULSE_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic                pll_reset_q, pll_reset_d;
    logic                rst_out_q, rst_out_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;
    logic                tmo_hit;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    // Counters default to zero so any state change clears them; only the
    // timeout timer survives STABLE->WAIT_LOCK so a glitching lock still times out.
    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = '0;
        stable_cnt_d = '0;
        tmo_cnt_d    = '0;
        retry_cnt_d  = retry_cnt_q;
        tmo_hit      = (tmo_cnt_q == TMO_LAST);
`ifdef PLL_SEQ_LOSS_CNT_EN
        lock_lost    = 1'b0;
`endif
        if (bus.relock_req) begin
            state_d     = ASSERT_RST;
            retry_cnt_d = '0;
        end else begin
            unique case (state_q)
                ASSERT_RST: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_d = WAIT_LOCK;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK, STABLE: begin
                    if (tmo_hit) begin
                        if (MAX_RETRIES != 0 && retry_cnt_q == RETRY_LAST) begin
                            state_d = FAULT;
                        end else begin
                            state_d     = ASSERT_RST;
                            retry_cnt_d = retry_inc(retry_cnt_q);
                        end
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                        if (state_q == WAIT_LOCK) begin
                            if (lock_s) begin
                                state_d = STABLE;
                            end
                        end else if (!lock_s) begin
                            state_d = WAIT_LOCK;
                        end else if (stable_cnt_q == STABLE_LAST) begin
                            state_d = RUN;
                        end else begin
                            stable_cnt_d = stable_cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = ASSERT_RST;
`ifdef PLL_SEQ_LOSS_CNT_EN
                        lock_lost = 1'b1;
`endif
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = ASSERT_RST;
                end
            endcase
        end
        if (state_d == RUN) begin
            retry_cnt_d = '0;
        end
    end

    // Outputs are registered from the next state so they move with state.
    always_comb begin
        pll_reset_d = (state_d == ASSERT_RST) || (state_d == FAULT);
        rst_out_d   = (state_d != RUN);
        ready_d     = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ASSERT_RST;
            pulse_cnt_q  <= '0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            pll_reset_q  <= 1'b1;
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_cnt_q  <= pulse_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            pll_reset_q  <= pll_reset_d;
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost && loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.loss_cnt = loss_cnt_q;
`endif

    assign bus.pll_reset = pll_reset_q;
    assign bus.rst_out   = rst_out_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_cnt_q;
    assign bus.state     = state_q;

endmodule
